// File: rtl/miner_pkg.sv
// rtl/miner_pkg.sv - shared widths and result record for the nonce collection path
package miner_pkg;

  localparam int NONCE_W    = 32;
  localparam int CORE_IDX_W = 8;

  typedef struct packed {
    logic [NONCE_W-1:0]    nonce;
    logic [CORE_IDX_W-1:0] core;
  } result_t;

endpackage

// File: rtl/result_fifo.sv
// rtl/result_fifo.sv - single-clock result FIFO with valid/ready read side
module result_fifo
  import miner_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic                   in_valid,
  input  result_t                in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output result_t                out_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  result_t        mem [DEPTH];
  logic  [AW:0]   wr_ptr;
  logic  [AW:0]   rd_ptr;
  logic           full;
  logic           rd_en;
  logic           wr_en;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count     = wr_ptr - rd_ptr;
  assign out_valid = (wr_ptr != rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en     = out_valid && out_ready;
  assign wr_en     = in_valid && (!full || rd_en);
  assign out_data  = out_valid ? mem[rd_ptr[AW-1:0]] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (rd_en) rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= in_data;
  end

endmodule

// File: rtl/nonce_collector.sv
// rtl/nonce_collector.sv - per-core hit holds, round-robin grant into a result FIFO
// Optional NONCE_COLLECTOR_DEDUP_EN: drop a grant equal to the last pushed entry.
module nonce_collector
  import miner_pkg::*;
#(
  parameter int CORES      = 1,
  parameter int LATENCY    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        clear,
  input  logic [CORES-1:0]            core_found,
  input  logic [32*CORES-1:0]         core_nonce,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NONCE_W-1:0]          out_nonce,
  output logic [CORE_IDX_W-1:0]       out_core,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow
);

  localparam int                 PTR_W    = (CORES > 1) ? $clog2(CORES) : 1;
  localparam int                 CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]      FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [NONCE_W-1:0] OFFSET   = NONCE_W'(CORES * LATENCY);

  logic [CORES-1:0]      slot_valid;
  logic [NONCE_W-1:0]    slot_nonce [CORES];
  logic [PTR_W-1:0]      rr_ptr;
  logic [CORES-1:0]      grant;
  logic [CORES-1:0]      drop;
  logic                  grant_any;
  logic [PTR_W-1:0]      grant_next;
  logic [NONCE_W-1:0]    grant_nonce;
  logic [CORE_IDX_W-1:0] grant_core;
  logic                  pop;
  logic                  can_push;
  logic                  push_valid;
  result_t               grant_rec;
  result_t               head;

  assign pop       = out_valid && out_ready;
  assign can_push  = (fifo_count < FULL_CNT) || pop;
  assign grant_rec = '{nonce: grant_nonce, core: grant_core};
  assign drop      = core_found & slot_valid & ~grant;

  // Two passes: cores at or after the pointer first, then the wrapped-around rest.
  always_comb begin
    grant       = '0;
    grant_any   = 1'b0;
    grant_next  = '0;
    grant_nonce = '0;
    grant_core  = '0;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < CORES; i++) begin
        if (can_push && !grant_any && slot_valid[i] &&
            ((pass == 0) == (PTR_W'(i) >= rr_ptr))) begin
          grant_any   = 1'b1;
          grant[i]    = 1'b1;
          grant_nonce = slot_nonce[i];
          grant_core  = CORE_IDX_W'(i);
          grant_next  = (i == CORES - 1) ? '0 : PTR_W'(i + 1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_valid <= '0;
      rr_ptr     <= '0;
      overflow   <= 1'b0;
      for (int i = 0; i < CORES; i++) slot_nonce[i] <= '0;
    end else if (clear) begin
      slot_valid <= '0;
      rr_ptr     <= '0;
      overflow   <= 1'b0;
    end else begin
      // A slot granted this edge is free to take a new hit on the same edge.
      for (int i = 0; i < CORES; i++) begin
        if (core_found[i] && !drop[i]) begin
          slot_valid[i] <= 1'b1;
          slot_nonce[i] <= core_nonce[32*i +: 32] - OFFSET;
        end else if (grant[i]) begin
          slot_valid[i] <= 1'b0;
        end
      end
      if (|drop)     overflow <= 1'b1;
      if (grant_any) rr_ptr   <= grant_next;
    end
  end

`ifdef NONCE_COLLECTOR_DEDUP_EN
  logic    last_valid;
  result_t last_entry;

  assign push_valid = grant_any && !(last_valid && (last_entry == grant_rec));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_valid <= 1'b0;
      last_entry <= '0;
    end else if (clear) begin
      last_valid <= 1'b0;
    end else if (push_valid) begin
      last_valid <= 1'b1;
      last_entry <= grant_rec;
    end
  end
`else
  assign push_valid = grant_any;
`endif

  result_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .in_valid  (push_valid),
    .in_data   (grant_rec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (head),
    .count     (fifo_count)
  );

  assign out_nonce = head.nonce;
  assign out_core  = head.core;

endmodule

// File: tb/tb_nonce_collector.sv
// tb/tb_nonce_collector.sv - self-checking bench for nonce_collector (1-core and 4-core builds)
module tb_nonce_collector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n;
  logic         clear;

  logic         found1;
  logic [31:0]  nonce1;
  logic         valid1, ready1, ovf1;
  logic [31:0]  onon1;
  logic [7:0]   ocore1;
  logic [2:0]   cnt1;

  logic [3:0]   found4;
  logic [127:0] nonce4;
  logic         valid4, ready4, ovf4;
  logic [31:0]  onon4;
  logic [7:0]   ocore4;
  logic [2:0]   cnt4;

  int vectors = 0;
  int miscompares = 0;

  nonce_collector #(.CORES(1), .LATENCY(1), .FIFO_DEPTH(4)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .core_found(found1), .core_nonce(nonce1),
    .out_valid(valid1), .out_ready(ready1), .out_nonce(onon1), .out_core(ocore1),
    .fifo_count(cnt1), .overflow(ovf1)
  );

  nonce_collector #(.CORES(4), .LATENCY(1), .FIFO_DEPTH(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .core_found(found4), .core_nonce(nonce4),
    .out_valid(valid4), .out_ready(ready4), .out_nonce(onon4), .out_core(ocore4),
    .fifo_count(cnt4), .overflow(ovf4)
  );

  typedef struct {
    logic [31:0] nonce;
    logic [7:0]  core;
  } ent_t;

  task automatic do_clear();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; clear = 1'b0;
    found1 = 1'b0; nonce1 = '0; ready1 = 1'b0;
    found4 = '0; nonce4 = '0; ready4 = 1'b0;
    #1;
    vectors++;
    if ({valid1, onon1, ocore1, cnt1, ovf1} !== 45'd0) begin
      miscompares++;
      $display("FAIL reset_dut1: got %h expected 0", {valid1, onon1, ocore1, cnt1, ovf1});
    end
    vectors++;
    if ({valid4, onon4, ocore4, cnt4, ovf4} !== 45'd0) begin
      miscompares++;
      $display("FAIL reset_dut4: got %h expected 0", {valid4, onon4, ocore4, cnt4, ovf4});
    end
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic test_basic();
    @(negedge clk); found1 = 1'b1; nonce1 = 32'h0000_0105;
    @(negedge clk); found1 = 1'b0;
    vectors++;
    if (valid1 !== 1'b0) begin
      miscompares++; $display("FAIL basic_early: out_valid=%b expected 0", valid1);
    end
    @(negedge clk);
    vectors++;
    if ({valid1, onon1, ocore1} !== {1'b1, 32'h0000_0104, 8'd0}) begin
      miscompares++;
      $display("FAIL basic_result: valid=%b nonce=%h core=%0d expected 1/00000104/0", valid1, onon1, ocore1);
    end
    ready1 = 1'b1;
    @(negedge clk);
    vectors++;
    if (valid1 !== 1'b0) begin
      miscompares++; $display("FAIL basic_pop: out_valid=%b expected 0", valid1);
    end
    ready1 = 1'b0;
  endtask

  task automatic test_wrap();
    do_clear();
    ready4 = 1'b1;
    for (int i = 0; i < 4; i++) nonce4[32*i +: 32] = $urandom();
    nonce4[95:64] = 32'h0000_0002;
    found4 = 4'b0100;
    @(negedge clk); found4 = '0;
    @(negedge clk);
    vectors++;
    if ({valid4, onon4, ocore4} !== {1'b1, 32'hFFFF_FFFE, 8'd2}) begin
      miscompares++;
      $display("FAIL wrap_result: valid=%b nonce=%h core=%0d expected 1/fffffffe/2", valid4, onon4, ocore4);
    end
    @(negedge clk);
    vectors++;
    if (valid4 !== 1'b0) begin
      miscompares++; $display("FAIL wrap_pop: out_valid=%b expected 0", valid4);
    end
  endtask

  task automatic test_all_cores();
    logic [31:0] n [4];
    do_clear();
    ready4 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n[i] = $urandom();
      nonce4[32*i +: 32] = n[i];
    end
    found4 = 4'hF;
    @(negedge clk); found4 = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if ({valid4, onon4, ocore4} !== {1'b1, n[i] - 32'd4, 8'(i)}) begin
        miscompares++;
        $display("FAIL all_cores_%0d: valid=%b nonce=%h core=%0d expected 1/%h/%0d",
                 i, valid4, onon4, ocore4, n[i] - 32'd4, i);
      end
    end
    @(negedge clk);
    vectors++;
    if (valid4 !== 1'b0) begin
      miscompares++; $display("FAIL all_cores_drain: out_valid=%b expected 0", valid4);
    end
    ready4 = 1'b0;
  endtask

  task automatic test_overflow();
    logic [31:0] n [6];
    do_clear();
    ready1 = 1'b0;
    for (int j = 0; j < 6; j++) n[j] = $urandom();
    @(negedge clk); found1 = 1'b1; nonce1 = n[0];
    for (int j = 1; j < 6; j++) begin
      @(negedge clk); nonce1 = n[j];
    end
    @(negedge clk); found1 = 1'b0;
    vectors++;
    if ({cnt1, ovf1, valid1, onon1} !== {3'd4, 1'b1, 1'b1, n[0] - 32'd1}) begin
      miscompares++;
      $display("FAIL overflow_full: count=%0d ovf=%b nonce=%h expected 4/1/%h", cnt1, ovf1, onon1, n[0] - 32'd1);
    end
    ready1 = 1'b1;
    @(negedge clk);
    vectors++;
    if ({cnt1, onon1} !== {3'd4, n[1] - 32'd1}) begin
      miscompares++;
      $display("FAIL full_push_pop: count=%0d nonce=%h expected 4/%h", cnt1, onon1, n[1] - 32'd1);
    end
    for (int j = 2; j < 5; j++) begin
      @(negedge clk);
      vectors++;
      if ({valid1, onon1} !== {1'b1, n[j] - 32'd1}) begin
        miscompares++;
        $display("FAIL overflow_order_%0d: valid=%b nonce=%h expected 1/%h", j, valid1, onon1, n[j] - 32'd1);
      end
    end
    @(negedge clk);
    vectors++;
    if ({valid1, cnt1, ovf1} !== {1'b0, 3'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL overflow_sticky: valid=%b count=%0d ovf=%b expected 0/0/1", valid1, cnt1, ovf1);
    end
    ready1 = 1'b0;
    found1 = 1'b1; nonce1 = $urandom();
    @(negedge clk); nonce1 = $urandom();
    @(negedge clk); found1 = 1'b0;
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    vectors++;
    if ({valid1, cnt1, ovf1} !== {1'b0, 3'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL clear_flush: valid=%b count=%0d ovf=%b expected 0/0/0", valid1, cnt1, ovf1);
    end
    @(negedge clk);
    vectors++;
    if (valid1 !== 1'b0) begin
      miscompares++; $display("FAIL clear_slots: out_valid=%b expected 0", valid1);
    end
  endtask

  task automatic test_reset_mid();
    do_clear();
    ready4 = 1'b0;
    nonce4 = {$urandom(), $urandom(), $urandom(), $urandom()};
    found4 = 4'b1001;
    @(negedge clk); found4 = '0;
    @(negedge clk);
    vectors++;
    if (valid4 !== 1'b1) begin
      miscompares++; $display("FAIL reset_mid_pre: out_valid=%b expected 1", valid4);
    end
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if ({valid4, onon4, ocore4, cnt4, ovf4} !== 45'd0) begin
      miscompares++;
      $display("FAIL reset_mid: got %h expected 0", {valid4, onon4, ocore4, cnt4, ovf4});
    end
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (valid4 !== 1'b0) begin
      miscompares++; $display("FAIL reset_mid_after: out_valid=%b expected 0", valid4);
    end
  endtask

  task automatic test_random();
    bit          m_v [4];
    logic [31:0] m_n [4];
    int          m_ptr;
    bit          m_ovf;
    ent_t        q [$];
    bit          pop, room;
    int          g;
    do_clear();
    found4 = '0; ready4 = 1'b0;
    for (int i = 0; i < 4; i++) begin m_v[i] = 1'b0; m_n[i] = '0; end
    m_ptr = 0; m_ovf = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      vectors++;
      if (valid4 !== (q.size() != 0)) begin
        miscompares++; $display("FAIL rand_valid cyc %0d: got %b expected %b", cyc, valid4, q.size() != 0);
      end
      vectors++;
      if (cnt4 !== 3'(q.size())) begin
        miscompares++; $display("FAIL rand_count cyc %0d: got %0d expected %0d", cyc, cnt4, q.size());
      end
      vectors++;
      if (ovf4 !== m_ovf) begin
        miscompares++; $display("FAIL rand_overflow cyc %0d: got %b expected %b", cyc, ovf4, m_ovf);
      end
      if (q.size() != 0) begin
        vectors++;
        if ({onon4, ocore4} !== {q[0].nonce, q[0].core}) begin
          miscompares++;
          $display("FAIL rand_head cyc %0d: got %h/%0d expected %h/%0d", cyc, onon4, ocore4, q[0].nonce, q[0].core);
        end
      end
      for (int i = 0; i < 4; i++) begin
        found4[i] = ($urandom_range(0, 3) == 0);
        nonce4[32*i +: 32] = $urandom();
      end
      ready4 = 1'($urandom_range(0, 1));
      clear  = ($urandom_range(0, 63) == 0);
      if (clear) begin
        for (int i = 0; i < 4; i++) m_v[i] = 1'b0;
        q.delete();
        m_ptr = 0; m_ovf = 1'b0;
      end else begin
        pop  = (q.size() != 0) && ready4;
        room = (q.size() < 4) || pop;
        g = -1;
        if (room) begin
          for (int k = 0; k < 4; k++) begin
            if (g < 0 && m_v[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
          end
        end
        if (pop) void'(q.pop_front());
        if (g >= 0) begin
          q.push_back('{nonce: m_n[g], core: 8'(g)});
          m_v[g] = 1'b0;
          m_ptr = (g + 1) % 4;
        end
        for (int i = 0; i < 4; i++) begin
          if (found4[i]) begin
            if (m_v[i]) m_ovf = 1'b1;
            else begin
              m_v[i] = 1'b1;
              m_n[i] = nonce4[32*i +: 32] - 32'd4;
            end
          end
        end
      end
    end
    @(negedge clk);
    found4 = '0; clear = 1'b0; ready4 = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_all_cores();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nonce_collector.md
NONCE_COLLECTOR -- requirements
Module: nonce_collector

Interface
REQ-001 SHALL have parameter CORES, default 1, number of miner cores feeding the block (1..256).
REQ-002 SHALL have parameter LATENCY, default 1, cycles between a core's nonce register holding the tested nonce and its found flag asserting.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, result FIFO entries (power of two, >=2).
REQ-004 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port clear  in  1  synchronous flush of holds, FIFO and overflow.
REQ-007 SHALL have port core_found  in  CORES  per-core found flag.
REQ-008 SHALL have port core_nonce  in  32*CORES  per-core current nonce, core i at bits [32i+31:32i].
REQ-009 SHALL have port out_valid  out  1  FIFO head valid.
REQ-010 SHALL have port out_ready  in  1  consumer accepts head.
REQ-011 SHALL have port out_nonce  out  32  corrected winning nonce.
REQ-012 SHALL have port out_core  out  8  index of the core that found it.
REQ-013 SHALL have port fifo_count  out  clog2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-014 SHALL have port overflow  out  1  sticky flag, a hit was lost.

Function
REQ-015 SHALL correct each hit as core_nonce_i - CORES*LATENCY, modulo 2^32 (wrap below zero is legal, no saturation).
REQ-016 SHALL keep one hold slot per core (valid bit, corrected nonce); on a clock edge with core_found[i]=1, slot i SHALL load the corrected nonce.
REQ-017 SHALL drop a hit arriving while slot i is valid and not granted in that cycle, keep the old slot contents, and set overflow.
REQ-018 SHALL allow slot i to be granted and reloaded on the same edge without a drop.
REQ-019 SHALL grant at most one valid slot per cycle to the FIFO, round-robin, starting search at the core after the last granted one; after reset the pointer is core 0.
REQ-020 SHALL grant only when fifo_count < FIFO_DEPTH or a pop (out_valid & out_ready) occurs in the same cycle.
REQ-021 SHALL pop the head when out_valid & out_ready; simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-022 SHALL hold out_nonce/out_core stable while out_valid=1 and out_ready=0.
REQ-023 SHALL give latency core_found edge -> out_valid of exactly 2 cycles with an empty FIFO and no competing slots.
REQ-024 SHALL, on clear=1, invalidate all slots, empty the FIFO, clear overflow and reset the RR pointer on that edge; hits presented in the same cycle are discarded.
REQ-025 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH with one extra bit for full/empty.

Reset
REQ-026 SHALL, while reset_n=0, force out_valid=0, out_nonce=0, out_core=0, fifo_count=0, overflow=0, all slots invalid, RR pointer=0, regardless of clk.
REQ-027 SHALL discard in-flight hits on reset assertion mid-operation; release SHALL be synchronised to clk internally by the integrating design.

Configuration
REQ-028 SHALL, with NONCE_COLLECTOR_DEDUP_EN defined, suppress a grant whose (nonce, core) equals the last pushed entry (slot freed, nothing pushed, overflow unaffected).
REQ-029 SHALL, without NONCE_COLLECTOR_DEDUP_EN, push every granted slot unconditionally.

Structure
REQ-030 SHALL place NONCE_W=32, CORE_IDX_W=8 and the result record type (nonce, core) in shared package miner_pkg.
REQ-031 SHALL implement the FIFO as sub-module result_fifo (sync, single clock, valid/ready read side).

Verification
REQ-032 SHALL check CORES=1, LATENCY=1: core_found=1 with core_nonce=0x00000105 for one cycle -> out_nonce=0x00000104, out_core=0 two cycles later.
REQ-033 SHALL check CORES=4: core_nonce=0x00000002, found -> out_nonce=0xFFFFFFFE (wrap).
REQ-034 SHALL check CORES=4, all cores found in the same cycle -> four results in core order 0,1,2,3 on consecutive cycles with out_ready=1.
REQ-035 SHALL check FIFO_DEPTH=4, out_ready=0, core 0 hit 6 times on consecutive cycles -> fifo_count=4, overflow=1, first four corrected nonces retained in order.
REQ-036 SHALL check a full FIFO with out_ready=1 and a pending slot -> push and pop on the same edge, fifo_count stays 4.
REQ-037 SHALL check reset_n low mid-stream with out_valid=1 -> outputs zero immediately without a clock edge; clear=1 -> empty and overflow=0 next cycle.
